// File: rtl/mp5_pkg.sv
// Shared mp5 stage types: packet format, FIFO slot and phantom map entry layouts.
package mp5_pkg;

    localparam int NUM_PIPELINES = 2;
    localparam int FIFO_SIZE     = 8;
    localparam int ID_W          = 16;
    localparam int PW            = (NUM_PIPELINES > 1) ? $clog2(NUM_PIPELINES) : 1;
    localparam int AW            = (FIFO_SIZE > 1) ? $clog2(FIFO_SIZE) : 1;

    typedef struct packed {
        logic [ID_W-1:0] id;
        logic            is_phantom;
        logic [31:0]     payload;
    } Packet;

    typedef struct packed {
        logic  valid;
        Packet pkt;
    } FIFO_Entry;

    // Location of one slot inside the stage: which FIFO and which address.
    typedef struct packed {
        logic [PW-1:0] fifo_id;
        logic [AW-1:0] addr;
    } Entry;

    typedef struct packed {
        logic            valid;
        logic [ID_W-1:0] id;
        logic [PW-1:0]   fifo_id;
        logic [AW-1:0]   addr;
    } map_entry_t;

endpackage

// File: rtl/mp5_phantom_map_if.sv
// Record / lookup / insert signal bundle between an mp5 stage and its phantom map.
interface mp5_phantom_map_if;
    import mp5_pkg::*;

    logic            rec_valid;
    logic [ID_W-1:0] rec_id;
    logic [PW-1:0]   rec_fifo_id;
    logic [AW-1:0]   rec_addr;
    logic            rec_ready;

    logic            pkt_valid;
    Packet           pkt_in;

    logic            insert_valid;
    logic [PW-1:0]   insert_fifo_id;
    logic [AW-1:0]   insert_addr;
    Packet           insert_pkt;

    logic            miss_valid;
    logic [ID_W-1:0] miss_id;

    modport master (
        output rec_valid, rec_id, rec_fifo_id, rec_addr, pkt_valid, pkt_in,
        input  rec_ready, insert_valid, insert_fifo_id, insert_addr, insert_pkt,
               miss_valid, miss_id
    );

    modport slave (
        input  rec_valid, rec_id, rec_fifo_id, rec_addr, pkt_valid, pkt_in,
        output rec_ready, insert_valid, insert_fifo_id, insert_addr, insert_pkt,
               miss_valid, miss_id
    );

endinterface

// File: rtl/mp5_free_slot_finder.sv
// Priority encoder: lowest set bit of a free-entry vector plus an any-free flag.
module mp5_free_slot_finder #(
    parameter  int DEPTH = 16,
    localparam int IW    = $clog2(DEPTH)
) (
    input  logic [DEPTH-1:0] free_vec,
    output logic [IW-1:0]    free_idx,
    output logic             any_free
);

    // Scanning downwards lets the lowest free index overwrite any higher one.
    always_comb begin
        free_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (free_vec[i]) free_idx = IW'(i);
        end
    end

    assign any_free = |free_vec;

endmodule

// File: rtl/mp5_phantom_map.sv
// Phantom id -> (fifo_id, addr) map issuing in-place insert commands for real packets.
// Optional entry aging is enabled by defining MP5_MAP_AGING_EN.
module mp5_phantom_map
    import mp5_pkg::*;
#(
    parameter int MAP_DEPTH = 16,
    parameter int AGE_LIMIT = 64
) (
    input  logic                      clk,
    input  logic                      rst,
    mp5_phantom_map_if.slave          bus,
    output logic [$clog2(MAP_DEPTH):0] occupancy,
    output logic                      overflow
);

    localparam int IW = $clog2(MAP_DEPTH);
    localparam int CW = IW + 1;

    if (((MAP_DEPTH & (MAP_DEPTH - 1)) != 0) || (AGE_LIMIT < 2)) begin : g_bad_param
        $error("mp5_phantom_map: MAP_DEPTH must be a power of 2 and AGE_LIMIT >= 2");
    end

    map_entry_t           table_q [MAP_DEPTH];
    map_entry_t           table_d [MAP_DEPTH];
    logic [MAP_DEPTH-1:0] rec_match;
    logic [MAP_DEPTH-1:0] pkt_match;
    logic [MAP_DEPTH-1:0] free_vec;
    logic [IW-1:0]        free_idx;
    logic                 any_free;
    logic                 rec_fire;
    logic                 lookup;
    logic                 bypass;
    logic                 hit;
    logic                 miss;
    logic                 rec_update;
    Entry                 hit_loc;
    logic [CW-1:0]        occ_d;

`ifdef MP5_MAP_AGING_EN
    localparam int             AGW     = $clog2(AGE_LIMIT);
    localparam logic [AGW-1:0] AGE_MAX = AGW'(AGE_LIMIT - 1);

    logic [AGW-1:0] age_q [MAP_DEPTH];
    logic [AGW-1:0] age_d [MAP_DEPTH];
`endif

    // CAM compare against the registered table only.
    always_comb begin
        for (int i = 0; i < MAP_DEPTH; i++) begin
            rec_match[i] = table_q[i].valid && (table_q[i].id == bus.rec_id);
            pkt_match[i] = table_q[i].valid && (table_q[i].id == bus.pkt_in.id);
            free_vec[i]  = !table_q[i].valid;
        end
    end

    mp5_free_slot_finder #(.DEPTH(MAP_DEPTH)) u_free (
        .free_vec (free_vec),
        .free_idx (free_idx),
        .any_free (any_free)
    );

    assign bus.rec_ready = (occupancy != CW'(MAP_DEPTH));
    assign rec_fire      = bus.rec_valid && bus.rec_ready;
    assign lookup        = bus.pkt_valid && !bus.pkt_in.is_phantom;
    // A record racing its own real packet is consumed straight into the insert.
    assign bypass        = rec_fire && lookup && (bus.rec_id == bus.pkt_in.id);
    assign rec_update    = rec_fire && !bypass;
    assign hit           = lookup && (bypass || (|pkt_match));
    assign miss          = lookup && !hit;

    always_comb begin
        hit_loc = '0;
        if (bypass) begin
            hit_loc.fifo_id = bus.rec_fifo_id;
            hit_loc.addr    = bus.rec_addr;
        end else begin
            for (int i = 0; i < MAP_DEPTH; i++) begin
                if (pkt_match[i]) begin
                    hit_loc.fifo_id = table_q[i].fifo_id;
                    hit_loc.addr    = table_q[i].addr;
                end
            end
        end
    end

    always_comb begin
        // NOTE: every comb output gets a full default first so no path can infer a latch.
        table_d = table_q;
`ifdef MP5_MAP_AGING_EN
        age_d = age_q;
`endif
        for (int i = 0; i < MAP_DEPTH; i++) begin
            if (lookup && pkt_match[i]) begin
                table_d[i].valid = 1'b0;
            end else if (rec_update && rec_match[i]) begin
                table_d[i].fifo_id = bus.rec_fifo_id;
                table_d[i].addr    = bus.rec_addr;
            end
`ifdef MP5_MAP_AGING_EN
            else if (table_q[i].valid && (age_q[i] == AGE_MAX)) begin
                table_d[i].valid = 1'b0;
            end
            if (rec_update && rec_match[i]) begin
                age_d[i] = '0;
            end else if (age_q[i] != AGE_MAX) begin
                age_d[i] = age_q[i] + 1'b1;
            end
`endif
        end
        // Allocation sees only slots free in the registered table.
        if (rec_update && !(|rec_match) && any_free) begin
            table_d[free_idx].valid   = 1'b1;
            table_d[free_idx].id      = bus.rec_id;
            table_d[free_idx].fifo_id = bus.rec_fifo_id;
            table_d[free_idx].addr    = bus.rec_addr;
`ifdef MP5_MAP_AGING_EN
            age_d[free_idx] = '0;
`endif
        end
    end

    always_comb begin
        occ_d = '0;
        for (int i = 0; i < MAP_DEPTH; i++) begin
            occ_d = occ_d + CW'(table_d[i].valid);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: only the valid bits are reset; id/fifo_id/addr are don't-care while invalid.
            for (int i = 0; i < MAP_DEPTH; i++) begin
                table_q[i].valid <= 1'b0;
            end
            occupancy          <= '0;
            overflow           <= 1'b0;
            bus.insert_valid   <= 1'b0;
            bus.insert_fifo_id <= '0;
            bus.insert_addr    <= '0;
            bus.insert_pkt     <= '0;
            bus.miss_valid     <= 1'b0;
            bus.miss_id        <= '0;
        end else begin
            table_q          <= table_d;
            occupancy        <= occ_d;
            overflow         <= overflow | (bus.rec_valid && !bus.rec_ready);
            bus.insert_valid <= hit;
            bus.miss_valid   <= miss;
            if (hit) begin
                bus.insert_fifo_id <= hit_loc.fifo_id;
                bus.insert_addr    <= hit_loc.addr;
                bus.insert_pkt     <= bus.pkt_in;
            end
            if (miss) begin
                bus.miss_id <= bus.pkt_in.id;
            end
        end
    end

`ifdef MP5_MAP_AGING_EN
    // Ages of invalid entries are ignored and cleared again on allocation.
    always_ff @(posedge clk) begin
        age_q <= age_d;
    end
`endif

endmodule

// File: tb/tb_mp5_phantom_map.sv
// Self-checking bench for mp5_phantom_map: associative-array model plus directed vectors.
`timescale 1ns/1ps
module tb_mp5_phantom_map;
    import mp5_pkg::*;

    localparam int DEPTH     = 16;
    localparam int AGE_LIMIT = 64;

    typedef struct packed {
        logic [PW-1:0] fifo_id;
        logic [AW-1:0] addr;
    } loc_t;

    logic                    clk = 1'b0;
    logic                    rst = 1'b1;
    logic [$clog2(DEPTH):0]  occupancy;
    logic                    overflow;

    mp5_phantom_map_if bus ();

    mp5_phantom_map #(.MAP_DEPTH(DEPTH), .AGE_LIMIT(AGE_LIMIT)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .occupancy (occupancy),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: the table is a map keyed by id; its size is the occupancy.
    loc_t        tbl [int];
    int          age [int];
    logic        exp_ins_v  = 1'b0;
    logic        exp_miss_v = 1'b0;
    logic        exp_ovf    = 1'b0;
    loc_t        exp_loc    = '0;
    Packet       exp_pkt    = '0;
    logic [15:0] exp_miss_id = '0;
    int          exp_occ    = 0;
    logic        model_live = 1'b0;

    always @(posedge clk) begin
        bit fire;
        bit look;
        bit same;
        int pk;
        int rk;
`ifdef MP5_MAP_AGING_EN
        int expired [$];
`endif
        if (rst) begin
            tbl.delete();
            age.delete();
            exp_ins_v  = 1'b0;
            exp_miss_v = 1'b0;
            exp_ovf    = 1'b0;
            exp_occ    = 0;
            model_live = 1'b1;
        end else begin
            pk   = int'(bus.pkt_in.id);
            rk   = int'(bus.rec_id);
            fire = bus.rec_valid && (tbl.num() != DEPTH);
            if (bus.rec_valid && !fire) exp_ovf = 1'b1;
            look = bus.pkt_valid && !bus.pkt_in.is_phantom;
            same = fire && look && (rk == pk);
            exp_ins_v  = 1'b0;
            exp_miss_v = 1'b0;
            if (look) begin
                if (same) begin
                    exp_ins_v = 1'b1;
                    exp_loc   = '{fifo_id: bus.rec_fifo_id, addr: bus.rec_addr};
                end else if (tbl.exists(pk)) begin
                    exp_ins_v = 1'b1;
                    exp_loc   = tbl[pk];
                end else begin
                    exp_miss_v  = 1'b1;
                    exp_miss_id = bus.pkt_in.id;
                end
                if (exp_ins_v) begin
                    exp_pkt = bus.pkt_in;
                    tbl.delete(pk);
                    age.delete(pk);
                end
            end
`ifdef MP5_MAP_AGING_EN
            expired.delete();
            foreach (age[k]) begin
                if (age[k] == AGE_LIMIT - 1) expired.push_back(k);
                else age[k] = age[k] + 1;
            end
            foreach (expired[j]) begin
                tbl.delete(expired[j]);
                age.delete(expired[j]);
            end
`endif
            if (fire && !same) begin
                tbl[rk] = '{fifo_id: bus.rec_fifo_id, addr: bus.rec_addr};
                age[rk] = 0;
            end
            exp_occ = tbl.num();
        end
    end

    always @(negedge clk) begin
        if (model_live) begin
            check("insert_valid", bus.insert_valid, exp_ins_v);
            if (exp_ins_v) begin
                check("insert_fifo_id", bus.insert_fifo_id, exp_loc.fifo_id);
                check("insert_addr", bus.insert_addr, exp_loc.addr);
                check("insert_pkt", bus.insert_pkt, exp_pkt);
            end
            check("miss_valid", bus.miss_valid, exp_miss_v);
            if (exp_miss_v) check("miss_id", bus.miss_id, exp_miss_id);
            check("occupancy", occupancy, exp_occ);
            check("rec_ready", bus.rec_ready, exp_occ != DEPTH);
            check("overflow", overflow, exp_ovf);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.rec_valid = 1'b0;
        bus.pkt_valid = 1'b0;
    endtask

    task automatic set_rec(input logic [15:0] id, input int f, input int a);
        bus.rec_valid   = 1'b1;
        bus.rec_id      = id;
        bus.rec_fifo_id = PW'(f);
        bus.rec_addr    = AW'(a);
    endtask

    task automatic set_pkt(input logic [15:0] id, input logic ph);
        bus.pkt_valid = 1'b1;
        bus.pkt_in    = '{id: id, is_phantom: ph, payload: {16'hC0DE, id}};
    endtask

    initial begin
        bus.rec_valid   = 1'b0;
        bus.rec_id      = '0;
        bus.rec_fifo_id = '0;
        bus.rec_addr    = '0;
        bus.pkt_valid   = 1'b0;
        bus.pkt_in      = '0;
        step();
        step();
        rst = 1'b0;
        check("lit_reset_occ", occupancy, 0);
        check("lit_reset_ready", bus.rec_ready, 1);
        check("lit_reset_ovf", overflow, 0);
        check("lit_reset_ins", bus.insert_valid, 0);
        check("lit_reset_miss", bus.miss_valid, 0);

        // Record then hit.
        set_rec(16'h0012, 1, 5);
        step();
        idle();
        check("lit_t1_occ1", occupancy, 1);
        set_pkt(16'h0012, 1'b0);
        step();
        idle();
        check("lit_t1_ins", bus.insert_valid, 1);
        check("lit_t1_fifo", bus.insert_fifo_id, 1);
        check("lit_t1_addr", bus.insert_addr, 5);
        check("lit_t1_pkt_id", bus.insert_pkt.id, 16'h0012);
        check("lit_t1_occ0", occupancy, 0);
        step();
        check("lit_t1_pulse", bus.insert_valid, 0);

        // Miss on empty table; phantom packets are ignored.
        set_pkt(16'h0099, 1'b0);
        step();
        idle();
        check("lit_t2_miss", bus.miss_valid, 1);
        check("lit_t2_miss_id", bus.miss_id, 16'h0099);
        check("lit_t2_noins", bus.insert_valid, 0);
        set_rec(16'h0055, 0, 1);
        step();
        idle();
        set_pkt(16'h0055, 1'b1);
        step();
        idle();
        check("lit_phantom_nomiss", bus.miss_valid, 0);
        check("lit_phantom_noins", bus.insert_valid, 0);
        check("lit_phantom_occ", occupancy, 1);
        set_pkt(16'h0055, 1'b0);
        step();
        idle();
        check("lit_55_ins", bus.insert_valid, 1);

        // Fill, overflow, free one, concurrent alloc and free, drain.
        for (int i = 0; i < DEPTH; i++) begin
            set_rec(16'h0100 + 16'(i), i % 2, i % 8);
            step();
        end
        idle();
        check("lit_full_occ", occupancy, 16);
        check("lit_full_ready", bus.rec_ready, 0);
        set_rec(16'h0200, 0, 0);
        step();
        idle();
        check("lit_ovf", overflow, 1);
        check("lit_ovf_occ", occupancy, 16);
        set_pkt(16'h0103, 1'b0);
        step();
        idle();
        check("lit_h3_ins", bus.insert_valid, 1);
        check("lit_h3_fifo", bus.insert_fifo_id, 1);
        check("lit_h3_addr", bus.insert_addr, 3);
        check("lit_h3_ready", bus.rec_ready, 1);
        check("lit_h3_occ", occupancy, 15);
        set_rec(16'h0300, 0, 4);
        set_pkt(16'h0104, 1'b0);
        step();
        idle();
        check("lit_both_ins_addr", bus.insert_addr, 4);
        check("lit_both_occ", occupancy, 15);
        for (int i = 0; i < DEPTH; i++) begin
            if (i != 3 && i != 4) begin
                set_pkt(16'h0100 + 16'(i), 1'b0);
                step();
            end
        end
        set_pkt(16'h0300, 1'b0);
        step();
        set_pkt(16'h0200, 1'b0);
        step();
        idle();
        check("lit_drop_miss", bus.miss_valid, 1);
        check("lit_drain_occ", occupancy, 0);

        // Same-cycle record and lookup of one id.
        set_rec(16'h0040, 0, 7);
        set_pkt(16'h0040, 1'b0);
        step();
        idle();
        check("lit_byp_ins", bus.insert_valid, 1);
        check("lit_byp_fifo", bus.insert_fifo_id, 0);
        check("lit_byp_addr", bus.insert_addr, 7);
        check("lit_byp_occ", occupancy, 0);

        // Re-record overwrites in place.
        set_rec(16'h0007, 0, 2);
        step();
        set_rec(16'h0007, 1, 6);
        step();
        idle();
        check("lit_ow_occ", occupancy, 1);
        step();
        set_pkt(16'h0007, 1'b0);
        step();
        idle();
        check("lit_ow_addr", bus.insert_addr, 6);
        check("lit_ow_fifo", bus.insert_fifo_id, 1);

`ifdef MP5_MAP_AGING_EN
        set_rec(16'h0001, 0, 3);
        step();
        idle();
        repeat (AGE_LIMIT - 1) step();
        check("lit_age_alive", occupancy, 1);
        step();
        check("lit_age_gone", occupancy, 0);
        set_pkt(16'h0001, 1'b0);
        step();
        idle();
        check("lit_age_miss", bus.miss_valid, 1);
`endif

        step();
        step();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
